display_tx_ctrl: RTL and testbench
==================================

Name: display_tx_ctrl

Overview:
- Display Transmission Control Unit: write-only I2C master that drives an SSD1306-class 128x64 OLED from the GPU side.
- On request it either sends a fixed initialisation command sequence, or streams one 1024-byte frame.
- Frame bytes are fetched from an external frame buffer through an address/data-request interface.
- Sits between the GPU frame memory and the SCL/SDA pads.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit I2C slave address (address byte on the wire = {DEV_ADDR,1'b0} = 8'h78).
- SCL_HALF, 16, clk cycles per SCL half-period (100 MHz clk gives 320 ns per bit).
- FRAME_BYTES, 1024, bytes per frame; data_address wraps after FRAME_BYTES-1.

Ports:
- clk, input, 1, system clock (100 MHz nominal).
- reset, input, 1, asynchronous, active-high reset.
- init_display, input, 1, start the init sequence; sampled when idle.
- send_frame, input, 1, start a frame transfer; sampled when idle.
- frame_data, input, 8, frame byte at data_address.
- SDA_IN, input, 1, sampled SDA line, used for ACK detection.
- data_address, output, 10, index of the next frame byte to load.
- get_next_data, output, 1, one-cycle strobe: current byte consumed.
- SCL, output, 1, I2C clock; idle high.
- SDA_OUT, output, 1, I2C data; 1 = release/high; idle high.
- busy, output, 1, transaction in progress.
- NACK, output, 1, sticky flag: slave did not acknowledge.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state: SCL=1, SDA_OUT=1, busy=0, NACK=0, get_next_data=0, data_address=0, FSM=IDLE. Reset mid-transfer returns the block to this state immediately; no STOP is generated.
- Start requests:
  - In IDLE, a level-high init_display or send_frame on a rising clk edge is accepted; busy rises on the next edge.
  - Both high together: init wins.
  - Requests while busy are ignored, not queued.
  - Accepting a request clears NACK.
- FSM states: IDLE, START, BYTE, ACK, STOP, BUSFREE.
- START: SDA_OUT falls while SCL=1, held SCL_HALF cycles, then SCL goes low.
- Bit timing:
  - Each bit is SCL_HALF cycles with SCL low, then SCL_HALF cycles with SCL high.
  - SDA_OUT changes only at the midpoint of the SCL-low phase.
  - Bits are sent MSB first.
- ACK bit: SDA_OUT=1 (released); SDA_IN is sampled at the midpoint of SCL high. SDA_IN=1 sets NACK.
- STOP:
  - SDA_OUT is driven low during SCL low; SCL rises.
  - After SCL_HALF cycles, SDA_OUT rises.
  - BUSFREE holds the bus idle for SCL_HALF cycles, then busy falls and the FSM returns to IDLE.
- Init transaction: START, 8'h78, control 8'h00, then 31 command bytes in order, then STOP.
  - Command bytes: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 21 00 7F 22 00 07 AF.
  - Total 33 bytes, about 96 us at defaults.
  - Commands come from an internal ROM indexed by a 5-bit counter.
- Frame transaction: START, 8'h78, control 8'h40, FRAME_BYTES data bytes, then STOP. About 2.96 ms at defaults.
- Frame fetch handshake:
  - data_address is reset to 0 when a frame is accepted.
  - frame_data is captured into the shift register on the load cycle of each data byte.
  - get_next_data pulses high for exactly that cycle.
  - data_address increments on the following edge, so the external memory has at least one full byte time (9 bits) to present the next byte.
  - After byte FRAME_BYTES-1 is loaded, data_address wraps to 0.
  - get_next_data pulses exactly FRAME_BYTES times per frame and never during init.
- data_address holds its value between frames and during init.

Optional Feature:
- Macro: DTCU_NACK_ABORT_EN.
- Defined: on NACK, the current byte finishes its ACK bit, then STOP and BUSFREE follow immediately and no further bytes are sent. busy falls afterward and NACK stays high.
- Undefined: NACK is flagged but the transaction continues to completion.

Test Plan:
- Reset pulse, no requests -> SCL=1, SDA_OUT=1, busy=0, NACK=0, data_address=0 held indefinitely.
- init_display pulsed 1 clk, SDA_IN=0 -> START, bytes 78 00 AE D5 ... AF decoded on the bus, STOP; busy falls within 110 us; get_next_data never asserted.
- send_frame pulsed after init, frame_data=8'h69 constant, SDA_IN=0 -> bytes 78 40 then 1024 copies of 69, STOP, busy low before 3.16 ms.
  - 1024 get_next_data pulses; data_address sweeps 0..1023 and ends at 0.
- Second send_frame 3160 us later -> identical frame transfer repeats.
- init_display and send_frame high in the same cycle -> init sequence only; a send_frame during busy is ignored.
- SDA_IN=1 during the address-byte ACK -> NACK=1 at that bit.
  - With DTCU_NACK_ABORT_EN: STOP follows at once.
  - Without it: the transfer completes.
  - In both cases the next accepted request clears NACK.

Source files
------------

// File: rtl/display_tx_ctrl.sv
// Write-only I2C master for an SSD1306-class OLED: sends the init command list or streams one frame.
// Optional macro DTCU_NACK_ABORT_EN: a NACK ends the transaction with STOP after the current ACK bit.
module display_tx_ctrl #(
   parameter logic [6:0]  DEV_ADDR    = 7'h3C,
   parameter int unsigned SCL_HALF    = 16,
   parameter int unsigned FRAME_BYTES = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       init_display,
   input  logic       send_frame,
   input  logic [7:0] frame_data,
   input  logic       SDA_IN,
   output logic [9:0] data_address,
   output logic       get_next_data,
   output logic       SCL,
   output logic       SDA_OUT,
   output logic       busy,
   output logic       NACK
);

   typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, BUSFREE} state_t;

   localparam logic [15:0] HALF_END   = 16'(SCL_HALF - 1);
   localparam logic [15:0] BIT_END    = 16'(2 * SCL_HALF - 1);
   localparam logic [15:0] MID_LOW    = 16'(SCL_HALF / 2);
   localparam logic [15:0] MID_HIGH   = 16'(SCL_HALF + SCL_HALF / 2);
   localparam logic [10:0] LAST_INIT  = 11'd32;
   localparam logic [10:0] LAST_FRAME = 11'(FRAME_BYTES + 1);
   localparam logic [9:0]  ADDR_LAST  = 10'(FRAME_BYTES - 1);

`ifdef DTCU_NACK_ABORT_EN
   localparam logic ABORT_ON_NACK = 1'b1;
`else
   localparam logic ABORT_ON_NACK = 1'b0;
`endif

   state_t      state, state_next;
   logic [15:0] cnt;
   logic [2:0]  bit_cnt;
   logic [10:0] byte_idx;
   logic [4:0]  cmd_idx;
   logic [7:0]  sh;
   logic        sda, nack, is_init;
   logic        bit_end, stop_now, load_next;

   function automatic logic [7:0] init_cmd(input logic [4:0] i);
      case (i)
         5'd0:  init_cmd = 8'hAE;  5'd1:  init_cmd = 8'hD5;  5'd2:  init_cmd = 8'h80;
         5'd3:  init_cmd = 8'hA8;  5'd4:  init_cmd = 8'h3F;  5'd5:  init_cmd = 8'hD3;
         5'd6:  init_cmd = 8'h00;  5'd7:  init_cmd = 8'h40;  5'd8:  init_cmd = 8'h8D;
         5'd9:  init_cmd = 8'h14;  5'd10: init_cmd = 8'h20;  5'd11: init_cmd = 8'h00;
         5'd12: init_cmd = 8'hA1;  5'd13: init_cmd = 8'hC8;  5'd14: init_cmd = 8'hDA;
         5'd15: init_cmd = 8'h12;  5'd16: init_cmd = 8'h81;  5'd17: init_cmd = 8'hCF;
         5'd18: init_cmd = 8'hD9;  5'd19: init_cmd = 8'hF1;  5'd20: init_cmd = 8'hDB;
         5'd21: init_cmd = 8'h40;  5'd22: init_cmd = 8'hA4;  5'd23: init_cmd = 8'hA6;
         5'd24: init_cmd = 8'h21;  5'd25: init_cmd = 8'h00;  5'd26: init_cmd = 8'h7F;
         5'd27: init_cmd = 8'h22;  5'd28: init_cmd = 8'h00;  5'd29: init_cmd = 8'h07;
         5'd30: init_cmd = 8'hAF;
         default: init_cmd = 8'hE3;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (init_display || send_frame) state_next = START;
         START:   if (cnt == HALF_END) state_next = BYTE;
         BYTE:    if (bit_end && bit_cnt == 3'd0) state_next = ACK;
         ACK:     if (bit_end) state_next = stop_now ? STOP : BYTE;
         STOP:    if (bit_end) state_next = BUSFREE;
         BUSFREE: if (cnt == HALF_END) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bit_end       = (cnt == BIT_END);
      stop_now      = (is_init ? (byte_idx == LAST_INIT) : (byte_idx == LAST_FRAME))
                      || (ABORT_ON_NACK && nack);
      load_next     = (state == ACK) && bit_end && !stop_now;
      get_next_data = load_next && !is_init && (byte_idx != 11'd0);
      busy          = (state != IDLE);
      NACK          = nack;
      SDA_OUT       = sda;
      case (state)
         BYTE, ACK, STOP: SCL = (cnt > HALF_END);
         default:         SCL = 1'b1;
      endcase
   end

   // SDA is registered so it only moves at the SCL-low midpoint; START/STOP edges come from state entry/exit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         bit_cnt      <= 3'd7;
         byte_idx     <= '0;
         cmd_idx      <= '0;
         sh           <= '1;
         sda          <= 1'b1;
         nack         <= 1'b0;
         is_init      <= 1'b0;
         data_address <= '0;
      end else begin
         if (state == IDLE || state_next != state || bit_end) cnt <= '0;
         else                                                  cnt <= cnt + 16'd1;
         case (state)
            IDLE: if (init_display || send_frame) begin
               is_init  <= init_display;
               nack     <= 1'b0;
               byte_idx <= '0;
               cmd_idx  <= '0;
               bit_cnt  <= 3'd7;
               sh       <= {DEV_ADDR, 1'b0};
               sda      <= 1'b0;
               if (!init_display) data_address <= '0;
            end
            BYTE: begin
               if (cnt == MID_LOW) sda <= sh[7];
               if (bit_end) begin
                  sh      <= {sh[6:0], 1'b0};
                  bit_cnt <= bit_cnt - 3'd1;
               end
            end
            ACK: begin
               if (cnt == MID_LOW) sda <= 1'b1;
               if (cnt == MID_HIGH && SDA_IN) nack <= 1'b1;
               if (load_next) begin
                  byte_idx <= byte_idx + 11'd1;
                  if (byte_idx == 11'd0) begin
                     sh <= is_init ? 8'h00 : 8'h40;
                  end else if (is_init) begin
                     sh      <= init_cmd(cmd_idx);
                     cmd_idx <= cmd_idx + 5'd1;
                  end else begin
                     sh           <= frame_data;
                     data_address <= (data_address == ADDR_LAST) ? '0 : data_address + 10'd1;
                  end
               end
            end
            STOP: begin
               if (cnt == MID_LOW) sda <= 1'b0;
               if (bit_end)        sda <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_display_tx_ctrl.sv
// Directed bench for display_tx_ctrl: decodes the I2C bus and checks bytes, fetch strobes and flags.
module tb_display_tx_ctrl;
   localparam int unsigned HALF = 4;
   localparam int unsigned FB   = 16;
   localparam int unsigned INIT_CYC  = HALF + 33 * 18 * HALF + 3 * HALF;
   localparam int unsigned FRAME_CYC = HALF + (FB + 2) * 18 * HALF + 3 * HALF;

   logic       clk = 1'b0, reset = 1'b1;
   logic       init_display = 1'b0, send_frame = 1'b0, SDA_IN = 1'b0;
   logic [7:0] frame_data = 8'h69;
   logic [9:0] data_address;
   logic       get_next_data, SCL, SDA_OUT, busy, NACK;

   int n_vec = 0, n_err = 0;
   bit pat_mode = 1'b0;

   logic [7:0] rx[$];
   logic [9:0] addrs[$];
   int starts, stops, gcnt, bcyc, bitn;
   logic [7:0] shr;
   logic prev_scl = 1'b1, prev_sda = 1'b1;

   logic [7:0] init_exp [33] = '{8'h78, 8'h00,
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20,
      8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40,
      8'hA4, 8'hA6, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF};

   display_tx_ctrl #(.DEV_ADDR(7'h3C), .SCL_HALF(HALF), .FRAME_BYTES(FB)) dut (
      .clk(clk), .reset(reset), .init_display(init_display), .send_frame(send_frame),
      .frame_data(frame_data), .SDA_IN(SDA_IN), .data_address(data_address),
      .get_next_data(get_next_data), .SCL(SCL), .SDA_OUT(SDA_OUT), .busy(busy), .NACK(NACK));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      frame_data = pat_mode ? (data_address[7:0] ^ 8'hA5) : 8'h69;
   end

   // Bus decoder: START/STOP on SDA edges while SCL high, data bits on SCL rise.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (SCL && prev_scl && !SDA_OUT && prev_sda) begin
            starts++; bitn = 0;
         end else if (SCL && prev_scl && SDA_OUT && !prev_sda) begin
            stops++; bitn = 0;
         end else if (SCL && !prev_scl) begin
            if (bitn < 8) begin
               shr = {shr[6:0], SDA_OUT};
               bitn++;
               if (bitn == 8) rx.push_back(shr);
            end else bitn = 0;
         end
         if (get_next_data) begin
            gcnt++;
            addrs.push_back(data_address);
         end
         if (busy) bcyc++;
      end
      prev_scl = SCL;
      prev_sda = SDA_OUT;
   end

   task automatic clear_mon();
      rx.delete(); addrs.delete();
      starts = 0; stops = 0; gcnt = 0; bcyc = 0; bitn = 0;
   endtask

   task automatic request(input logic do_init, input logic do_frame);
      @(negedge clk);
      init_display = do_init;
      send_frame   = do_frame;
      @(negedge clk);
      init_display = 1'b0;
      send_frame   = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      for (int n = 0; n < budget && busy; n++) @(negedge clk);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_init(input string tag);
      check({tag, "_nbytes"}, 32'(rx.size()), 32'd33);
      for (int i = 0; i < 33 && i < rx.size(); i++)
         check($sformatf("%s_b%0d", tag, i), 32'(rx[i]), 32'(init_exp[i]));
      check({tag, "_starts"}, 32'(starts), 32'd1);
      check({tag, "_stops"}, 32'(stops), 32'd1);
      check({tag, "_gets"}, 32'(gcnt), 32'd0);
   endtask

   task automatic run_frame(input string tag, input bit pat);
      pat_mode = pat;
      clear_mon();
      request(1'b0, 1'b1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      wait_idle(3000, tag);
      check({tag, "_nbytes"}, 32'(rx.size()), 32'(FB + 2));
      if (rx.size() >= 2) begin
         check({tag, "_addr_byte"}, 32'(rx[0]), 32'h78);
         check({tag, "_ctrl_byte"}, 32'(rx[1]), 32'h40);
      end
      for (int k = 0; k < FB && k + 2 < rx.size(); k++)
         check($sformatf("%s_d%0d", tag, k), 32'(rx[k + 2]), pat ? 32'(8'(k) ^ 8'hA5) : 32'h69);
      check({tag, "_gets"}, 32'(gcnt), 32'(FB));
      for (int k = 0; k < addrs.size(); k++)
         check($sformatf("%s_a%0d", tag, k), 32'(addrs[k]), 32'(k));
      check({tag, "_addr_end"}, 32'(data_address), 32'd0);
      check({tag, "_cycles"}, 32'(bcyc), 32'(FRAME_CYC));
      check({tag, "_stops"}, 32'(stops), 32'd1);
      check({tag, "_nack"}, 32'(NACK), 32'd0);
   endtask

   initial begin
      clear_mon();
      repeat (3) @(negedge clk);
      check("rst_scl", 32'(SCL), 32'd1);
      check("rst_sda", 32'(SDA_OUT), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_nack", 32'(NACK), 32'd0);
      check("rst_addr", 32'(data_address), 32'd0);
      check("rst_get", 32'(get_next_data), 32'd0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("hold_scl", 32'(SCL), 32'd1);
      check("hold_sda", 32'(SDA_OUT), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_addr", 32'(data_address), 32'd0);

      // init sequence
      clear_mon();
      request(1'b1, 1'b0);
      check("init_busy", 32'(busy), 32'd1);
      wait_idle(4000, "init");
      check_init("init");
      check("init_cycles", 32'(bcyc), 32'(INIT_CYC));
      check("init_addr", 32'(data_address), 32'd0);

      run_frame("frame1", 1'b0);
      run_frame("frame2", 1'b1);
      run_frame("frame3", 1'b0);

      // simultaneous requests, then a request while busy
      clear_mon();
      request(1'b1, 1'b1);
      check("both_busy", 32'(busy), 32'd1);
      repeat (200) @(negedge clk);
      send_frame = 1'b1;
      @(negedge clk);
      send_frame = 1'b0;
      wait_idle(4000, "both");
      repeat (20) @(negedge clk);
      check("both_after_busy", 32'(busy), 32'd0);
      check_init("both");

      // NACK on the address byte
      pat_mode = 1'b0;
      clear_mon();
      request(1'b0, 1'b1);
      for (int n = 0; n < 2000 && rx.size() < 1 && busy; n++) @(negedge clk);
      SDA_IN = 1'b1;
      for (int n = 0; n < 2000 && rx.size() < 2 && busy; n++) @(negedge clk);
      SDA_IN = 1'b0;
      check("nack_set", 32'(NACK), 32'd1);
      wait_idle(3000, "nack");
`ifdef DTCU_NACK_ABORT_EN
      check("nack_nbytes", 32'(rx.size()), 32'd1);
      check("nack_gets", 32'(gcnt), 32'd0);
      check("nack_cycles", 32'(bcyc), 32'(HALF + 18 * HALF + 3 * HALF));
`else
      check("nack_nbytes", 32'(rx.size()), 32'(FB + 2));
      check("nack_gets", 32'(gcnt), 32'(FB));
      check("nack_cycles", 32'(bcyc), 32'(FRAME_CYC));
`endif
      check("nack_stops", 32'(stops), 32'd1);
      check("nack_sticky", 32'(NACK), 32'd1);

      clear_mon();
      request(1'b1, 1'b0);
      check("nack_cleared", 32'(NACK), 32'd0);
      wait_idle(4000, "reinit");
      check_init("reinit");

      // reset in the middle of a frame
      request(1'b0, 1'b1);
      repeat (300) @(negedge clk);
      check("mid_addr_moved", 32'(data_address != 10'd0), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midrst_scl", 32'(SCL), 32'd1);
      check("midrst_sda", 32'(SDA_OUT), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_addr", 32'(data_address), 32'd0);
      check("midrst_get", 32'(get_next_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("post_busy", 32'(busy), 32'd0);
      check("post_scl", 32'(SCL), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
